// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC sharing controller.
// Holds the FSM encoding, default widths and the round-robin pointer wrap helper.
package cordic_ctrl_pkg;

    localparam int CC_DATA_W  = 32;
    localparam int CC_TIMEOUT = 15;

    localparam logic [CC_DATA_W-1:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int wrap_inc(input int id, input int n);
        return (id == n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/cordic_share_ctrl_rr_pick.sv
// Rotating-priority select: picks the first set request at or above rr_ptr,
// wrapping past the top requester back to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        // Walk from the farthest offset down so the nearest hit overwrites the rest.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Time-shares one iterative cosine CORDIC core among N_REQ requesters, returning
// tagged results on one response channel, with a watchdog that flushes a hung core.
//
//   state | meaning
//   IDLE  | waiting for any req_valid; grants and latches operand/id
//   ISSUE | one-cycle core_start, busy counter cleared
//   BUSY  | waiting for core_done, busy counter running
//   RESP  | response held on rsp_* until rsp_ready
module cordic_share_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = CC_DATA_W,
    parameter int TIMEOUT = CC_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    aclr_n,
    input  logic                    clk_en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    input  logic                    rsp_ready,
    output logic                    core_start,
    output logic [DATA_W-1:0]       core_dataa,
    output logic                    core_flush,
    input  logic                    core_done,
    input  logic [DATA_W-1:0]       core_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [N_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   rr_ptr;
    logic [DATA_W-1:0] operand_q;
    logic [CNT_W-1:0]  busy_cnt;
    logic              cnt_tc;
    logic              flush_pulse;
    logic              go;
    logic [DATA_W-1:0] req_word [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_word
        assign req_word[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    // Handshake-side outputs are suppressed while frozen or in reset, since no
    // edge would act on them.
    assign go         = clk_en & aclr_n;
    assign cnt_tc     = (busy_cnt == CNT_W'(TIMEOUT));
    assign core_flush = ~aclr_n | flush_pulse;
    assign core_dataa = operand_q;
    assign rsp_id     = id_q;

    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (core_done || cnt_tc) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        core_start  = 1'b0;
        flush_pulse = 1'b0;
        case (state)
            IDLE:    if (go) req_ready = pick_grant;
            ISSUE:   core_start = go;
            BUSY:    flush_pulse = go & ~core_done & cnt_tc;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            operand_q <= '0;
            id_q      <= '0;
            rr_ptr    <= '0;
            busy_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        operand_q <= req_word[pick_id];
                        id_q      <= pick_id;
                    end
                end
                ISSUE: busy_cnt <= '0;
                BUSY: begin
                    busy_cnt <= busy_cnt + CNT_W'(1);
                    // A done arriving on the timeout cycle still delivers a result.
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= core_result;
                        rsp_err   <= 1'b0;
                    end else if (cnt_tc) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= DATA_W'(FP32_ZERO);
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ID_W'(wrap_inc(int'(id_q), N_REQ));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Bench for cordic_share_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of grants and responses.
`timescale 1ns/1ps
module tb_cordic_share_ctrl;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int LAT_OK  = 5;
    localparam int LAT_TO  = 3 + TIMEOUT;

    logic                    clock = 1'b0;
    logic                    aclr_n;
    logic                    clk_en;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    rsp_ready;
    logic                    core_start;
    logic [DATA_W-1:0]       core_dataa;
    logic                    core_flush;
    logic                    core_done;
    logic [DATA_W-1:0]       core_result;

    always #5 clock = ~clock;

    cordic_share_ctrl #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .clk_en      (clk_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready),
        .core_start  (core_start),
        .core_dataa  (core_dataa),
        .core_flush  (core_flush),
        .core_done   (core_done),
        .core_result (core_result)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Transaction model: one outstanding request, its grant cycle and pauses since.
    bit          m_busy, m_started, m_timeout, exp_rv_q;
    int          m_ptr, m_id, m_acc, m_paused;
    logic [31:0] m_data;

    // Observed DUT events, used by the directed timing checks.
    int dacc_id[$];
    int dacc_cyc[$];
    int d_rise, d_hs;
    bit prev_rv;

    // Core model: done three enabled edges after start, frozen by clk_en.
    bit          core_never, done_next;
    int          core_pend;
    logic [31:0] core_arg;

    function automatic logic [31:0] cos_model(logic [31:0] a);
        if (a == 32'h3F00_0000) return 32'h3F60_A8B6;
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic int rr_model(logic [N_REQ-1:0] v, int ptr);
        logic [N_REQ-1:0] sh;
        for (int k = 0; k < N_REQ; k++) begin
            sh = v >> ((ptr + k) % N_REQ);
            if (sh[0]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    endtask

    // Evaluates the current cycle with the inputs already applied, then advances one clock.
    task automatic cycle();
        logic [N_REQ-1:0] exp_ready;
        bit exp_rv, exp_start, exp_flush;
        int g, lat, oid;
        #1;
        if (rsp_valid && !prev_rv) d_rise = cyc;
        if (clk_en && rsp_valid && rsp_ready) d_hs = cyc;
        if (req_ready != '0) begin
            oid = 0;
            for (int k = 0; k < N_REQ; k++) if (req_ready[k]) oid = k;
            dacc_id.push_back(oid);
            dacc_cyc.push_back(cyc);
        end
        prev_rv = rsp_valid;

        if (!aclr_n) begin
            chk("flush_in_reset", core_flush, 1);
            chk("ready_in_reset", req_ready, 0);
            chk("start_in_reset", core_start, 0);
            m_busy   = 0;
            m_ptr    = 0;
            exp_rv_q = 0;
        end else begin
            lat    = m_timeout ? LAT_TO : LAT_OK;
            exp_rv = m_busy && (cyc >= m_acc + lat + m_paused);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_timeout);
                chk("rsp_data", rsp_data, m_timeout ? 32'h0 : cos_model(m_data));
            end
            exp_flush = clk_en && m_busy && m_timeout && (cyc == m_acc + lat - 1 + m_paused);
            chk("core_flush", core_flush, exp_flush);
            exp_start = clk_en && m_busy && !m_started;
            chk("core_start", core_start, exp_start);
            if (exp_start) begin
                chk("core_dataa", core_dataa, m_data);
                m_started = 1;
            end
            g = (clk_en && !m_busy) ? rr_model(req_valid, m_ptr) : -1;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            if (m_busy && !clk_en && !exp_rv) m_paused++;
            if (exp_rv && clk_en && rsp_ready) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % N_REQ;
            end
            if (g >= 0) begin
                m_busy    = 1;
                m_id      = g;
                m_data    = req_data[g*DATA_W +: DATA_W];
                m_acc     = cyc;
                m_paused  = 0;
                m_started = 0;
                m_timeout = core_never;
            end
            exp_rv_q = exp_rv;
        end

        if (core_flush) begin
            core_pend = 0;
            done_next = 0;
        end else if (!clk_en) begin
            done_next = core_done;
        end else begin
            done_next = 0;
            if (core_start && !core_never) begin
                core_pend = 3;
                core_arg  = core_dataa;
            end
            if (core_pend > 0) begin
                core_pend--;
                done_next = (core_pend == 0);
            end
        end

        @(posedge clock);
        #1;
        cyc++;
        core_done   = done_next;
        core_result = done_next ? cos_model(core_arg) : $urandom;
    endtask

    task automatic wait_accept(int budget);
        int sz = dacc_id.size();
        int n  = 0;
        while (dacc_id.size() == sz && n < budget) begin
            cycle();
            n++;
        end
        chk("accept_in_budget", dacc_id.size() != sz, 1);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            cycle();
            n++;
        end
        chk("idle_in_budget", m_busy, 0);
    endtask

    task automatic rand_data();
        for (int r = 0; r < N_REQ; r++) req_data[r*DATA_W +: DATA_W] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base, sz, n;
        bit  want_never;
        aclr_n      = 1'b0;
        clk_en      = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        rsp_ready   = 1'b1;
        core_done   = 1'b0;
        core_result = '0;
        core_never  = 0;
        core_pend   = 0;
        done_next   = 0;
        m_busy      = 0;
        m_ptr       = 0;
        exp_rv_q    = 0;
        prev_rv     = 0;
        d_rise      = 0;
        d_hs        = 0;
        @(posedge clock);
        #1;
        cycle();
        cycle();
        aclr_n = 1'b1;
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_core_dataa", core_dataa, 0);

        // All four requesters: served 0,1,2,3 six cycles apart.
        rand_data();
        req_valid = 4'hF;
        base = dacc_id.size();
        sz   = base;
        n    = 0;
        while (dacc_id.size() < base + 4 && n < 60) begin
            cycle();
            n++;
            if (dacc_id.size() > sz) begin
                req_valid[dacc_id[$]] = 1'b0;
                sz = dacc_id.size();
            end
        end
        chk("all4_count", dacc_id.size() - base, 4);
        if (dacc_id.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) chk("all4_order", dacc_id[base+k], k);
            for (int k = 1; k < 4; k++) chk("all4_gap", dacc_cyc[base+k] - dacc_cyc[base+k-1], 6);
        end
        wait_idle(20);

        // Requests 0 and 3 together: pointer has wrapped, so 0 first.
        req_valid = 4'b1001;
        wait_accept(10);
        chk("wrap_first", dacc_id[$], 0);
        req_valid = 4'b1000;
        wait_idle(20);
        wait_accept(10);
        chk("wrap_second", dacc_id[$], 3);
        req_valid = '0;
        wait_idle(20);

        // Single request, reference latency.
        rand_data();
        req_data[63:32] = 32'h3F00_0000;
        req_valid = 4'b0010;
        wait_accept(10);
        req_valid = '0;
        wait_idle(20);
        chk("single_id", dacc_id[$], 1);
        chk("single_lat", d_rise - dacc_cyc[$], LAT_OK);

        // Backpressure: response held 10 cycles while another requester waits.
        rsp_ready = 1'b0;
        rand_data();
        req_valid = 4'b0100;
        wait_accept(10);
        req_valid = 4'b0101;
        n = 0;
        while (!rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_rsp_seen", rsp_valid, 1);
        for (int k = 0; k < 10; k++) cycle();
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("bp_next_grant", dacc_cyc[$] - d_hs, 1);
        chk("bp_next_id", dacc_id[$], 0);
        req_valid = '0;
        wait_idle(20);

        // Hung core: timeout error, then a normal grant.
        core_never = 1;
        rand_data();
        req_valid = 4'b0010;
        wait_accept(10);
        req_valid = '0;
        wait_idle(40);
        chk("to_lat", d_rise - dacc_cyc[$], LAT_TO);
        core_never = 0;
        req_valid = 4'b1000;
        wait_accept(10);
        req_valid = '0;
        wait_idle(20);
        chk("after_to_lat", d_rise - dacc_cyc[$], LAT_OK);

        // clk_en low for 3 cycles in BUSY delays the response by exactly 3.
        rand_data();
        req_valid = 4'b0001;
        wait_accept(10);
        req_valid = '0;
        cycle();
        clk_en = 1'b0;
        cycle();
        cycle();
        cycle();
        clk_en = 1'b1;
        wait_idle(20);
        chk("pause_lat", d_rise - dacc_cyc[$], LAT_OK + 3);

        // Reset mid-BUSY, then a stale done that must be ignored.
        rand_data();
        req_valid = 4'b0100;
        wait_accept(10);
        req_valid = '0;
        cycle();
        cycle();
        aclr_n = 1'b0;
        cycle();
        aclr_n = 1'b1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_core_dataa", core_dataa, 0);
        core_done   = 1'b1;
        core_result = 32'hDEAD_BEEF;
        for (int k = 0; k < 8; k++) cycle();
        req_valid = 4'hF;
        wait_accept(10);
        chk("midrst_ptr", dacc_id[$], 0);
        req_valid = '0;
        wait_idle(20);

        // Randomized traffic with stalls, backpressure and occasional hung core.
        want_never = 0;
        for (int i = 0; i < 700; i++) begin
            if ((i % 175) == 120) want_never = ~want_never;
            if (!m_busy) core_never = want_never;
            req_valid = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rand_data();
            rsp_ready = ($urandom_range(0, 9) < 7);
            clk_en    = ($urandom_range(0, 9) != 0);
            cycle();
        end
        req_valid = '0;
        clk_en    = 1'b1;
        rsp_ready = 1'b1;
        wait_idle(40);
        core_never = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
